// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: drives the shared mon_prod Montgomery multiplier through a
// full left-to-right square-and-multiply modular exponentiation.
//
// The host preloads x_bar = R mod n at mon_prod address 0 and M_bar at
// address 2, then pulses go. For each exponent bit this block issues one
// squaring (OPXX), followed by one multiply (OPXM) if the bit is set. A final
// OPX1 takes the result out of the Montgomery domain. The result is left at
// mon_prod address 0, and done pulses for one cycle.
//
// Optional build macro: MODEXP_SKIP_LZ_EN
//   When defined, leading zero exponent bits below exp_len are skipped. The
//   start index comes from a same-cycle priority encoder. Squaring x_bar = R
//   gives R again, so skipping those bits does not change the result.
//   When undefined, every bit from exp_len-1 down to 0 is processed.
//
// State table:
//   state | meaning
//   IDLE  | waiting for go; outputs quiescent except ops_done (holds last count)
//   ISSUE | mp_start high for one cycle with the current op code
//   ACK   | mon_prod is still dropping stop; mp_stop is not looked at
//   WAIT  | op in flight; op code held; on mp_stop pick the next op or finish
//   DONE  | one-cycle done pulse, busy still high

module mod_exp_ctrl #(
  parameter int EBITS      = 256,
  parameter int LOG_EBITS  = 8,
  parameter int LOG_BITLEN = 8,
  parameter int MP_COUNT   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [EBITS-1:0]      exponent,
  input  logic [LOG_EBITS:0]    exp_len,
  output logic                  mp_start,
  output logic [1:0]            mp_op_code,
  output logic [LOG_BITLEN:0]   mp_count,
  input  logic                  mp_stop,
  output logic                  busy,
  output logic                  done,
  output logic [LOG_EBITS+1:0]  ops_done
);

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACK   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [EBITS-1:0]      exp_q;
  logic [LOG_EBITS-1:0]  idx;

  logic [LOG_EBITS:0]    len_clamp;
  logic [LOG_EBITS-1:0]  start_idx;
  logic [1:0]            start_op;

  logic [LOG_EBITS-1:0]  next_idx;
  logic [1:0]            next_op;
  logic                  finish;
  logic                  cur_bit;

  // The iteration count handed to mon_prod never changes.
  assign mp_count = (LOG_BITLEN+1)'(MP_COUNT);

  // Clamp the requested length so that idx never points past the exponent.
  always_comb begin
    len_clamp = exp_len;
    if (exp_len > (LOG_EBITS+1)'(EBITS))
      len_clamp = (LOG_EBITS+1)'(EBITS);
  end

`ifdef MODEXP_SKIP_LZ_EN
  logic                  lz_found;
  logic [LOG_EBITS-1:0]  lz_idx;

  // Priority encoder: the highest set exponent bit below the clamped length.
  // The loop runs upward, so the last hit wins.
  always_comb begin
    lz_found = 1'b0;
    lz_idx   = '0;
    for (int i = 0; i < EBITS; i++) begin
      if (exponent[i] && ((LOG_EBITS+1)'(i) < len_clamp)) begin
        lz_found = 1'b1;
        lz_idx   = LOG_EBITS'(i);
      end
    end
  end

  // A zero exponent in range behaves like exp_len = 0: only the OPX1 op runs.
  always_comb begin
    start_op  = lz_found ? OPXX : OPX1;
    start_idx = lz_found ? lz_idx : '0;
  end
`else
  // Start at the top processed bit. idx is a don't-care when exp_len is 0.
  always_comb begin
    start_op  = (len_clamp != '0) ? OPXX : OPX1;
    start_idx = LOG_EBITS'(len_clamp - (LOG_EBITS+1)'(1));
  end
`endif

  assign cur_bit = exp_q[idx];

  // Choose the op that follows the one just completed.
  always_comb begin
    next_op  = OPX1;
    next_idx = idx;
    finish   = 1'b0;
    case (mp_op_code)
      OPXX: begin
        if (cur_bit) begin
          next_op = OPXM;
        end else if (idx == '0) begin
          next_op = OPX1;
        end else begin
          next_op  = OPXX;
          next_idx = idx - LOG_EBITS'(1);
        end
      end
      OPXM: begin
        if (idx == '0) begin
          next_op = OPX1;
        end else begin
          next_op  = OPXX;
          next_idx = idx - LOG_EBITS'(1);
        end
      end
      default: finish = 1'b1;
    endcase
  end

  // Sequencer FSM. All outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mp_start   <= 1'b0;
      mp_op_code <= OPXX;
      busy       <= 1'b0;
      done       <= 1'b0;
      ops_done   <= '0;
      idx        <= '0;
      exp_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            exp_q      <= exponent;
            ops_done   <= '0;
            busy       <= 1'b1;
            idx        <= start_idx;
            mp_op_code <= start_op;
            mp_start   <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mp_start <= 1'b0;
          ops_done <= ops_done + (LOG_EBITS+2)'(1);
          state    <= S_ACK;
        end
        S_ACK: begin
          // mon_prod still shows the stale stop level during this cycle.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mp_stop) begin
            if (finish) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mp_op_code <= next_op;
              idx        <= next_idx;
              mp_start   <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mp_start <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed testbench for mod_exp_ctrl, using a small behavioural mon_prod
// model. In the model, stop falls one cycle after start and rises six
// cycles later.
module tb_mod_exp_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         go = 1'b0;
  logic [255:0] exponent = '0;
  logic [8:0]   exp_len = '0;
  logic         mp_start;
  logic [1:0]   mp_op_code;
  logic [8:0]   mp_count;
  logic         mp_stop = 1'b1;
  logic         busy;
  logic         done;
  logic [9:0]   ops_done;

  int vec_count  = 0;
  int miss_count = 0;

  logic [1:0] op_log[$];
  logic [1:0] exp_seq[$];
  int         done_cnt    = 0;
  int         stable_err  = 0;
  int         overlap_err = 0;
  logic [1:0] cur_op = 2'd0;
  int         cnt = 0;
  logic       active = 1'b0;

  mod_exp_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .exponent   (exponent),
    .exp_len    (exp_len),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .mp_stop    (mp_stop),
    .busy       (busy),
    .done       (done),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // mon_prod model: logs each issued op and flags op-code changes while in flight
  always @(posedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (mp_start) begin
      if (active) overlap_err = overlap_err + 1;
      op_log.push_back(mp_op_code);
      cur_op  <= mp_op_code;
      mp_stop <= 1'b0;
      cnt     <= 6;
      active  <= 1'b1;
    end else if (active) begin
      if (mp_op_code !== cur_op) stable_err = stable_err + 1;
      if (cnt == 1) begin
        mp_stop <= 1'b1;
        active  <= 1'b0;
      end
      cnt <= cnt - 1;
    end
  end

  function automatic int seq_diff(input int base);
    if (op_log.size() - base != exp_seq.size()) return -2;
    for (int i = 0; i < exp_seq.size(); i++)
      if (op_log[base+i] !== exp_seq[i]) return i;
    return -1;
  endfunction

  task automatic run(input logic [255:0] e, input logic [8:0] len,
                     output bit busy_seen, output bit timed_out);
    @(negedge clk);
    go = 1'b1; exponent = e; exp_len = len;
    @(negedge clk);
    go = 1'b0;
    busy_seen = busy;
    timed_out = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("FAIL reset_busy got %0d want 0", busy); end
    vec_count++; if (done !== 1'b0) begin miss_count++; $display("FAIL reset_done got %0d want 0", done); end
    vec_count++; if (mp_start !== 1'b0) begin miss_count++; $display("FAIL reset_mp_start got %0d want 0", mp_start); end
    vec_count++; if (mp_op_code !== 2'd0) begin miss_count++; $display("FAIL reset_op got %0d want 0", mp_op_code); end
    vec_count++; if (ops_done !== 10'd0) begin miss_count++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
    vec_count++; if (mp_count !== 9'd256) begin miss_count++; $display("FAIL mp_count got %0d want 256", mp_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b0, d0, s0; bit bs, to, to2, bs2;
    b0 = op_log.size(); d0 = done_cnt; s0 = stable_err;
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    run(256'hB, 9'd4, bs, to);
    vec_count++; if (bs !== 1'b1) begin miss_count++; $display("FAIL basic_busy got %0d want 1", bs); end
    vec_count++; if (to) begin miss_count++; $display("FAIL basic_timeout got timeout want done"); end
    vec_count++; if (seq_diff(b0) != -1) begin miss_count++; $display("FAIL basic_seq got diff %0d (len %0d) want match len 8", seq_diff(b0), op_log.size()-b0); end
    vec_count++; if (ops_done !== 10'd8) begin miss_count++; $display("FAIL basic_ops_done got %0d want 8", ops_done); end
    vec_count++; if (done_cnt - d0 != 1) begin miss_count++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
    vec_count++; if (stable_err != s0) begin miss_count++; $display("FAIL basic_op_stable got %0d changes want 0", stable_err - s0); end
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("FAIL basic_busy_end got %0d want 0", busy); end
    // 0x6 over 3 bits: XX,XM, XX,XM, XX, X1
    b0 = op_log.size();
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
    run(256'h6, 9'd3, bs2, to2);
    vec_count++; if (seq_diff(b0) != -1 || to2) begin miss_count++; $display("FAIL six_seq got diff %0d want match", seq_diff(b0)); end
    vec_count++; if (ops_done !== 10'd6) begin miss_count++; $display("FAIL six_ops_done got %0d want 6", ops_done); end
  endtask

  task automatic test_len0();
    int b0, d0; bit seen_low, to;
    b0 = op_log.size(); d0 = done_cnt;
    exp_seq = '{2'd2};
    @(negedge clk);
    go = 1'b1; exponent = 256'hFF; exp_len = 9'd0;
    @(negedge clk);
    go = 1'b0;
    seen_low = 1'b0; to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!mp_stop) seen_low = 1'b1;
      else if (seen_low) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    vec_count++; if (to || done !== 1'b1) begin miss_count++; $display("FAIL len0_done_timing got done=%0d timeout=%0d want done=1", done, to); end
    @(negedge clk);
    vec_count++; if (seq_diff(b0) != -1) begin miss_count++; $display("FAIL len0_seq got diff %0d want single X1", seq_diff(b0)); end
    vec_count++; if (ops_done !== 10'd1) begin miss_count++; $display("FAIL len0_ops_done got %0d want 1", ops_done); end
    vec_count++; if (done_cnt - d0 != 1) begin miss_count++; $display("FAIL len0_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_leading_zero();
    int b0; bit bs, to;
    b0 = op_log.size();
`ifdef MODEXP_SKIP_LZ_EN
    exp_seq = '{2'd0, 2'd1, 2'd2};
`else
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
`endif
    run(256'h1, 9'd8, bs, to);
    vec_count++; if (to || seq_diff(b0) != -1) begin miss_count++; $display("FAIL lz_seq got diff %0d want match", seq_diff(b0)); end
`ifdef MODEXP_SKIP_LZ_EN
    vec_count++; if (ops_done !== 10'd3) begin miss_count++; $display("FAIL lz_ops_done got %0d want 3", ops_done); end
`else
    vec_count++; if (ops_done !== 10'd10) begin miss_count++; $display("FAIL lz_ops_done got %0d want 10", ops_done); end
`endif
  endtask

  task automatic test_back_to_back();
    int b0, o0, d0; bit to;
    b0 = op_log.size(); o0 = overlap_err; d0 = done_cnt;
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    @(negedge clk);
    go = 1'b1; exponent = 256'hB; exp_len = 9'd4;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    go = 1'b1; exponent = 256'h0; exp_len = 9'd0;
    @(negedge clk);
    go = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    // go in the done cycle must be ignored
    go = 1'b1; exponent = 256'h3; exp_len = 9'd2;
    @(negedge clk);
    go = 1'b0;
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("FAIL go_at_done_busy got %0d want 0", busy); end
    repeat (5) @(negedge clk);
    vec_count++; if (to || seq_diff(b0) != -1) begin miss_count++; $display("FAIL go_busy_seq got diff %0d want match", seq_diff(b0)); end
    vec_count++; if (ops_done !== 10'd8) begin miss_count++; $display("FAIL go_busy_ops_done got %0d want 8", ops_done); end
    vec_count++; if (overlap_err != o0) begin miss_count++; $display("FAIL overlap got %0d want 0", overlap_err - o0); end
    vec_count++; if (done_cnt - d0 != 1) begin miss_count++; $display("FAIL go_busy_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_run();
    int b0; bit bs, to, to2;
    b0 = op_log.size();
    @(negedge clk);
    go = 1'b1; exponent = 256'hB; exp_len = 9'd4;
    @(negedge clk);
    go = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (op_log.size() - b0 >= 3) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_count++; if (to || busy !== 1'b0) begin miss_count++; $display("FAIL rst_mid_busy got %0d want 0", busy); end
    vec_count++; if (mp_start !== 1'b0) begin miss_count++; $display("FAIL rst_mid_mp_start got %0d want 0", mp_start); end
    vec_count++; if (ops_done !== 10'd0) begin miss_count++; $display("FAIL rst_mid_ops_done got %0d want 0", ops_done); end
    to2 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (mp_stop) begin to2 = 1'b0; break; end
      @(negedge clk);
    end
    b0 = op_log.size();
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    run(256'h3, 9'd2, bs, to);
    vec_count++; if (to || to2 || seq_diff(b0) != -1) begin miss_count++; $display("FAIL rst_rerun_seq got diff %0d want match", seq_diff(b0)); end
    vec_count++; if (ops_done !== 10'd5) begin miss_count++; $display("FAIL rst_rerun_ops_done got %0d want 5", ops_done); end
  endtask

  task automatic test_clamp();
    int b0, xm, s0; bit bs, to; logic [1:0] first_op, last_op;
    b0 = op_log.size(); s0 = stable_err;
    run({256{1'b1}}, 9'd300, bs, to);
    xm = 0;
    for (int i = b0; i < op_log.size(); i++) if (op_log[i] == 2'd1) xm++;
    first_op = (op_log.size() > b0) ? op_log[b0] : 2'd3;
    last_op  = (op_log.size() > b0) ? op_log[op_log.size()-1] : 2'd3;
    vec_count++; if (to || ops_done !== 10'd513) begin miss_count++; $display("FAIL clamp_ops_done got %0d want 513", ops_done); end
    vec_count++; if (op_log.size() - b0 != 513) begin miss_count++; $display("FAIL clamp_issued got %0d want 513", op_log.size() - b0); end
    vec_count++; if (xm != 256) begin miss_count++; $display("FAIL clamp_xm_count got %0d want 256", xm); end
    vec_count++; if (first_op !== 2'd0 || last_op !== 2'd2) begin miss_count++; $display("FAIL clamp_ends got %0d/%0d want 0/2", first_op, last_op); end
    vec_count++; if (stable_err != s0) begin miss_count++; $display("FAIL clamp_op_stable got %0d want 0", stable_err - s0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_leading_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
